// File: rtl/stim_sequencer_if.sv
// Bundle for stim_sequencer: synchronous ROM read port plus the outgoing
// valid/ready beat stream.
interface stim_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  rom_strobe;
  logic                  rom_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output rom_en, rom_addr,
    input  rom_data, rom_strobe, rom_last,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  rom_en, rom_addr,
    output rom_data, rom_strobe, rom_last,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/stim_sequencer.sv
// Stimulus ROM sequencer: reads the ROM, drops strobe=0 entries, emits a beat stream
// with inter-packet gaps and repeated passes. Optional STIM_SEQ_BEAT_COUNT_EN adds beat_count.
module stim_sequencer #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [7:0]              repeat_count,
  input  logic [15:0]             gap_cycles,
  stim_sequencer_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              passes
`ifdef STIM_SEQ_BEAT_COUNT_EN
  ,
  output logic [31:0]             beat_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            rep_lat;
  logic [15:0]           gap_lat;
  logic [15:0]           gap_cnt;
  logic                  in_flight;
  logic [DATA_WIDTH:0]   fifo_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH:0]   head;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  issue;
  logic                  start_ok;
  logic                  stop_ok;
  logic [7:0]            passes_next;
  logic [2:0]            committed;

  assign stop_ok     = stop && (state != ST_IDLE);
  assign start_ok    = start && !stop && ((state == ST_IDLE) || (state == ST_DONE));
  assign fifo_empty  = (fifo_cnt == 2'd0);
  assign head        = fifo_mem[rd_ptr];
  assign passes_next = (passes == 8'hFF) ? 8'hFF : passes + 8'd1;

  assign bus.out_valid = !fifo_empty && (gap_cnt == 16'd0);
  assign bus.out_data  = bus.out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign bus.out_last  = bus.out_valid && head[DATA_WIDTH];
  assign fifo_pop      = bus.out_valid && bus.out_ready;
  assign fifo_push     = in_flight && bus.rom_strobe;

  // A beat leaving this cycle frees its slot, so it is credited before issuing a new read.
  assign committed    = {1'b0, fifo_cnt} + {2'b0, in_flight} - {2'b0, fifo_pop};
  assign issue        = (state == ST_RUN) && !stop && (committed < 3'd2);
  assign bus.rom_en   = issue;
  assign bus.rom_addr = addr;

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      passes  <= '0;
      rep_lat <= '0;
      gap_lat <= '0;
    end else if (stop_ok) begin
      state <= ST_IDLE;
      addr  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state   <= ST_RUN;
            rep_lat <= repeat_count;
            gap_lat <= gap_cycles;
            addr    <= '0;
            passes  <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (addr == LAST_ADDR) begin
              passes <= passes_next;
              addr   <= '0;
              if ((rep_lat != 8'd0) && (passes_next == rep_lat)) state <= ST_DRAIN;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!in_flight && fifo_empty) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stop_ok) begin
      in_flight <= 1'b0;
      fifo_cnt  <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      gap_cnt   <= 16'd0;
    end else begin
      in_flight <= issue;
      fifo_cnt  <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
      if (fifo_push) wr_ptr <= ~wr_ptr;
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      if (fifo_pop && head[DATA_WIDTH]) gap_cnt <= gap_lat;
      else if (gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push && !rst && !stop_ok) fifo_mem[wr_ptr] <= {bus.rom_last, bus.rom_data};
  end

`ifdef STIM_SEQ_BEAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) beat_count <= 32'd0;
    else if (fifo_pop) beat_count <= beat_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed + randomized bench for stim_sequencer; expected beat streams are built
// from the ROM image (strobed entries, repeated per pass) and compared in order.
module tb_stim_sequencer;
  localparam int DEPTH = 64;
  localparam int AW    = 8;
  localparam int DW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  repeat_count = 8'd0;
  logic [15:0] gap_cycles = 16'd0;
  logic        busy;
  logic        done;
  logic [7:0]  passes;
`ifdef STIM_SEQ_BEAT_COUNT_EN
  logic [31:0] beat_count;
`endif

  stim_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();

  stim_sequencer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .repeat_count (repeat_count),
    .gap_cycles   (gap_cycles),
    .bus          (sif),
    .busy         (busy),
    .done         (done),
    .passes       (passes)
`ifdef STIM_SEQ_BEAT_COUNT_EN
    ,
    .beat_count   (beat_count)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_data   [DEPTH];
  logic          mem_strobe [DEPTH];
  logic          mem_last   [DEPTH];

  // Synchronous ROM: word appears the cycle after rom_en.
  always @(posedge clk) begin
    if (sif.rom_en) begin
      sif.rom_data   <= mem_data[sif.rom_addr[5:0]];
      sif.rom_strobe <= mem_strobe[sif.rom_addr[5:0]];
      sif.rom_last   <= mem_last[sif.rom_addr[5:0]];
    end
  end

  int total = 0;
  int bad = 0;

  logic [DW:0] exp_q[$];
  int expected_total, gap_need;
  int cyc, reads, beats, en_count, max_out;
  int gap_viol, hold_viol, addr_viol, since_last;
  int first_beat_cyc, last_beat_cyc;
  logic seen_last, prev_stall;
  logic [DW:0] prev_word;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    cyc = 0; reads = 0; beats = 0; en_count = 0; max_out = 0;
    gap_viol = 0; hold_viol = 0; addr_viol = 0; since_last = 0;
    first_beat_cyc = -1; last_beat_cyc = -1;
    seen_last = 1'b0; prev_stall = 1'b0; prev_word = '0;
  endtask

  function automatic logic pickReady(input int mode);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 1) return pat[cyc % 4];
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // One clock: drive inputs at negedge, observe settled outputs, update the model.
  task automatic applyStimulus(input logic rdy, input logic st, input logic sp);
    logic [DW:0] word;
    logic [DW:0] e;
    @(negedge clk);
    sif.out_ready = rdy;
    start = st;
    stop  = sp;
    #1;
    cyc++;
    word = {sif.out_last, sif.out_data};
    if (sif.rom_en) begin
      if (sif.rom_addr !== AW'(reads % DEPTH)) addr_viol++;
      reads++;
      en_count++;
    end
    if (prev_stall && !(sif.out_valid && word === prev_word)) hold_viol++;
    prev_stall = sif.out_valid && !rdy;
    prev_word  = word;
    if (sif.out_valid) begin
      if (seen_last && since_last < gap_need) gap_viol++;
      seen_last = 1'b0;
    end else if (seen_last) begin
      since_last++;
    end
    if (sif.out_valid && rdy) begin
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beats++;
      if (exp_q.size() == 0) begin
        checkOutput("extra_beat", 64'(beats), 64'(expected_total));
      end else begin
        e = exp_q.pop_front();
        checkOutput("beat", 64'(word), 64'(e));
      end
      if (sif.out_last) begin
        seen_last  = 1'b1;
        since_last = 0;
      end
    end
    if (reads - beats > max_out) max_out = reads - beats;
  endtask

  task automatic startRun(input logic [7:0] rep, input logic [15:0] gap, input int model_passes,
                          input logic rdy);
    clearModel();
    exp_q.delete();
    for (int p = 0; p < model_passes; p++)
      for (int i = 0; i < DEPTH; i++)
        if (mem_strobe[i]) exp_q.push_back({mem_last[i], mem_data[i]});
    expected_total = exp_q.size();
    gap_need = int'(gap);
    repeat_count = rep;
    gap_cycles = gap;
    applyStimulus(rdy, 1'b1, 1'b0);
  endtask

  task automatic runUntilDone(input int budget, input int mode, input string tag);
    int n;
    n = 0;
    do begin
      applyStimulus(pickReady(mode), 1'b0, 1'b0);
      n++;
    end while (!done && n < budget);
    checkOutput({tag, "_done"}, 64'(done), 64'(1));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    clearModel();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rom_en"},    64'(sif.rom_en),    64'(0));
    checkOutput({tag, "_rom_addr"},  64'(sif.rom_addr),  64'(0));
    checkOutput({tag, "_out_valid"}, 64'(sif.out_valid), 64'(0));
    checkOutput({tag, "_out_data"},  64'(sif.out_data),  64'(0));
    checkOutput({tag, "_out_last"},  64'(sif.out_last),  64'(0));
    checkOutput({tag, "_busy"},      64'(busy),          64'(0));
    checkOutput({tag, "_done"},      64'(done),          64'(0));
    checkOutput({tag, "_passes"},    64'(passes),        64'(0));
  endtask

  task automatic loadSmallRom();
    for (int i = 0; i < DEPTH; i++) begin
      mem_data[i]   = $urandom;
      mem_strobe[i] = (i < 4);
      mem_last[i]   = (i == 3);
    end
  endtask

  initial begin
    int exp_passes;
    sif.out_ready = 1'b0;
    clearModel();
    gap_need = 0;
    expected_total = 0;

    // Power-on reset
    pulseReset();
    checkResetOutputs("reset");

    // Four-beat packet, single pass, no gap: latency and back-to-back beats
    loadSmallRom();
    startRun(8'd1, 16'd0, 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s1_first_rom_en", 64'(sif.rom_en), 64'(1));
    checkOutput("s1_first_rom_addr", 64'(sif.rom_addr), 64'(0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s1_no_early_valid", 64'(sif.out_valid), 64'(0));
    runUntilDone(300, 0, "s1");
    checkOutput("s1_beats", 64'(beats), 64'(4));
    checkOutput("s1_first_beat_cyc", 64'(first_beat_cyc), 64'(4));
    checkOutput("s1_last_beat_cyc", 64'(last_beat_cyc), 64'(7));
    checkOutput("s1_passes", 64'(passes), 64'(1));
    checkOutput("s1_busy", 64'(busy), 64'(0));
`ifdef STIM_SEQ_BEAT_COUNT_EN
    checkOutput("s1_beat_count", 64'(beat_count), 64'(beats));
`endif

    // Three passes with a five-cycle gap after each last
    startRun(8'd3, 16'd5, 3, 1'b1);
    runUntilDone(800, 0, "s2");
    checkOutput("s2_beats", 64'(beats), 64'(12));
    checkOutput("s2_gap_viol", 64'(gap_viol), 64'(0));
    checkOutput("s2_passes", 64'(passes), 64'(3));

    // Every entry strobed, ready pattern 1,0,0,1
    for (int i = 0; i < DEPTH; i++) begin
      mem_data[i]   = $urandom;
      mem_strobe[i] = 1'b1;
      mem_last[i]   = (i % 16 == 15);
    end
    startRun(8'd1, 16'd0, 1, 1'b1);
    runUntilDone(1000, 1, "s3");
    checkOutput("s3_beats", 64'(beats), 64'(64));
    checkOutput("s3_outstanding_le2", 64'(max_out <= 2), 64'(1));
    checkOutput("s3_hold_viol", 64'(hold_viol), 64'(0));
    checkOutput("s3_addr_viol", 64'(addr_viol), 64'(0));

    // Random ROM, random ready, two passes, random gap
    for (int i = 0; i < DEPTH; i++) begin
      mem_data[i]   = $urandom;
      mem_strobe[i] = 1'($urandom_range(0, 1));
      mem_last[i]   = ($urandom_range(0, 3) == 0);
    end
    begin
      logic [15:0] g;
      g = 16'($urandom_range(0, 4));
      startRun(8'd2, g, 2, 1'b1);
    end
    runUntilDone(3000, 2, "s4");
    checkOutput("s4_beats", 64'(beats), 64'(expected_total));
    checkOutput("s4_gap_viol", 64'(gap_viol), 64'(0));
    checkOutput("s4_hold_viol", 64'(hold_viol), 64'(0));
    checkOutput("s4_addr_viol", 64'(addr_viol), 64'(0));
    checkOutput("s4_passes", 64'(passes), 64'(2));

    // Infinite run stopped after 100 cycles
    loadSmallRom();
    startRun(8'd0, 16'd0, 4, 1'b1);
    repeat (99) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s5_still_busy", 64'(busy), 64'(1));
    applyStimulus(1'b1, 1'b0, 1'b1);
    exp_passes = reads / DEPTH;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s5_busy", 64'(busy), 64'(0));
    checkOutput("s5_done", 64'(done), 64'(0));
    checkOutput("s5_out_valid", 64'(sif.out_valid), 64'(0));
    checkOutput("s5_rom_en", 64'(sif.rom_en), 64'(0));
    checkOutput("s5_passes_held", 64'(passes), 64'(exp_passes));
    checkOutput("s5_addr_viol", 64'(addr_viol), 64'(0));

    // Reset while a beat is stalled, then restart from address 0
    startRun(8'd1, 16'd0, 1, 1'b0);
    for (int k = 0; k < 10 && !sif.out_valid; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s6_valid_before_rst", 64'(sif.out_valid), 64'(1));
    pulseReset();
    checkResetOutputs("s6_rst");
    startRun(8'd1, 16'd0, 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s6_restart_rom_en", 64'(sif.rom_en), 64'(1));
    checkOutput("s6_restart_addr", 64'(sif.rom_addr), 64'(0));
    runUntilDone(300, 0, "s6");
    checkOutput("s6_beats", 64'(beats), 64'(4));

    // Start and stop together from DONE
    applyStimulus(1'b1, 1'b1, 1'b1);
    en_count = 0;
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s7_done", 64'(done), 64'(0));
    checkOutput("s7_busy", 64'(busy), 64'(0));
    checkOutput("s7_no_reads", 64'(en_count), 64'(0));

    // Pass counter saturation on an endless run with nothing strobed
    for (int i = 0; i < DEPTH; i++) begin
      mem_strobe[i] = 1'b0;
      mem_last[i]   = 1'b0;
    end
    startRun(8'd0, 16'd0, 0, 1'b1);
    repeat (256 * DEPTH + 20) applyStimulus(1'b1, 1'b0, 1'b0);
    exp_passes = (reads / DEPTH > 255) ? 255 : reads / DEPTH;
    checkOutput("s8_passes_sat", 64'(passes), 64'(exp_passes));
    checkOutput("s8_busy", 64'(busy), 64'(1));
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s8_stopped", 64'(busy), 64'(0));
    checkOutput("s8_passes_held", 64'(passes), 64'(255));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
- Controller for the synchronous stimulus ROMs (data/strobe/last, 64 entries) that feed the BPF packet filter during hardware tests.
- Sequences ROM reads, drops idle (strobe=0) entries and emits an AXI-Stream-like beat stream with backpressure.
- Inserts a programmable inter-packet gap and replays the ROM a programmable number of passes.
- Sits between the stimulus ROMs and the filter's packet input.

Parameters:
- DEPTH, 64, number of ROM entries per pass.
- ADDR_WIDTH, 8, ROM address width; must satisfy DEPTH <= 2^ADDR_WIDTH.
- DATA_WIDTH, 32, ROM/stream data width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run; accepted in IDLE or DONE only.
- stop  in  1  pulse; aborts the run; wins over start in the same cycle.
- repeat_count  in  8  passes per run, latched on start; 0 = infinite.
- gap_cycles  in  16  idle cycles after each accepted last beat, latched on start.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_data  in  DATA_WIDTH  ROM data, valid 1 cycle after rom_en.
- rom_strobe  in  1  entry-valid bit, same timing as rom_data.
- rom_last  in  1  end-of-packet bit, same timing as rom_data.
- out_data  out  DATA_WIDTH  beat data.
- out_valid  out  1  beat valid.
- out_last  out  1  last beat of packet.
- out_ready  in  1  downstream accept.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- passes  out  8  completed passes in current run; saturates at 255.

Behaviour:
- Reset state: all outputs 0; FSM IDLE; FIFO empty; counters 0.
- FSM states:
  - IDLE: start -> RUN; latch repeat_count and gap_cycles; rom_addr=0; passes=0.
  - RUN: issue reads (see fetch rule below).
    - When the read of address DEPTH-1 is issued: passes increments, in the same cycle its data returns.
    - If the new passes equals latched repeat_count (nonzero) -> DRAIN. Otherwise rom_addr wraps to 0.
  - DRAIN: no reads. -> DONE when no read is in flight and the FIFO is empty.
  - DONE: done=1; start -> RUN (same as from IDLE).
- stop in any state except IDLE: next cycle IDLE; FIFO flushed; in-flight read discarded; gap counter cleared; passes held.
- Fetch rule: rom_en=1 in RUN when (FIFO occupancy + reads in flight) < 2 and stop=0.
  - FIFO is 2 entries deep.
  - rom_addr advances by 1 per issued read.
- Return path:
  - Cycle after rom_en, the returned word is written to the FIFO only if rom_strobe=1.
  - Entries with strobe=0 are dropped and consume no output cycle.
- Output side:
  - out_valid = FIFO non-empty AND gap_cnt==0; out_data and out_last come from the FIFO head.
  - A beat transfers when out_valid && out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Gap:
  - On transfer of a beat with out_last=1, gap_cnt loads gap_cycles.
  - gap_cnt decrements each cycle while nonzero.
  - Fetching continues during the gap (FIFO may fill).
- Latency: start accepted at edge N; rom_en=1, rom_addr=0 during cycle N..N+1; data written at edge N+2; out_valid=1 after edge N+2.
  - Steady-state throughput: 1 beat/cycle with out_ready held high and all strobes 1.
- Boundaries:
  - FIFO full with out_ready=0: rom_en=0; no beat is lost.
  - Simultaneous FIFO write and read: occupancy unchanged.
  - repeat_count=0: RUN never exits except via stop.
  - passes saturates at 255; it does not wrap.
  - start while busy: ignored.
  - rst mid-run: IDLE next cycle; all outputs 0.

Optional Feature:
- STIM_SEQ_BEAT_COUNT_EN
  - Defined: adds output beat_count (32 bits), incremented on every transferred beat, cleared on accepted start and on rst; wraps at 2^32.
  - Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ROM entries 0..3 strobe=1, entry 3 last=1, entries 4..63 strobe=0; repeat_count=1, gap_cycles=0, out_ready=1.
  -> 4 beats 0..3 on consecutive cycles starting 2 cycles after start; last on beat 3; passes=1; done=1 after the read of address 63 plus drain.
- Same ROM, repeat_count=3, gap_cycles=5.
  -> 12 beats total; out_valid low >=5 cycles after each last; passes=3; done=1.
- All 64 entries strobe=1, out_ready toggling 1,0,0,1 pattern.
  -> all 64 words emitted exactly once, in order; no drops or duplicates; rom_en never issues a 3rd outstanding word.
- repeat_count=0, stop pulse asserted 100 cycles after start.
  -> IDLE next cycle; out_valid=0; busy=0; done=0; passes holds its value.
- rst asserted mid-packet with out_valid=1, out_ready=0.
  -> next cycle all outputs 0; a subsequent start restarts from address 0.
- start and stop in the same cycle from DONE.
  -> stays in IDLE; no rom_en.
